// File: rtl/patp_control_unit.sv
// patp_control_unit
// -----------------
// Fetch/execute sequencer for the PATP core. Holds the program counter and
// instruction register, runs the single-port program/data memory over a
// req/ready handshake, and strobes exec_en for one cycle whenever the decoder
// and accumulator datapath must act on the latched instruction.
//
// Optional feature: define PATP_CTRL_SINGLE_STEP_EN to add the `step` input,
// which runs exactly one instruction from IDLE.
//
// Ports:
//   step       in   1       (PATP_CTRL_SINGLE_STEP_EN only) run one instruction
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   start      in   1       begin execution from IDLE at current pc
//   stop       in   1       halt at the next instruction boundary
//   mem_ready  in   1       memory completes the current request this cycle
//   mem_rdata  in   DATA_W  memory read data, valid with mem_ready
//   acc_zero   in   1       accumulator-equals-zero flag (BUZ condition)
//   mem_req    out  1       memory request (registered)
//   mem_we     out  1       request is a STORE write (registered)
//   mem_addr   out  ADDR_W  request address (registered)
//   ir_opcode  out  3       latched opcode
//   ir_operand out  ADDR_W  latched operand
//   pc         out  ADDR_W  program counter
//   exec_en    out  1       one-cycle decoder enable
//   retire     out  1       one-cycle pulse on the last cycle of an instruction
//   running    out  1       high in every state except IDLE
module patp_control_unit #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
`ifdef PATP_CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              acc_zero,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        ir_opcode,
  output logic [ADDR_W-1:0] ir_operand,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_en,
  output logic              retire,
  output logic              running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    MEM   = 2'd3
  } state_t;

  localparam logic [2:0] OP_JUMP  = 3'b100;
  localparam logic [2:0] OP_BUZ   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_STORE = 3'b111;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              stop_pending;
  logic              pending_next;
  logic              ir_load;

  // Next-state, pc update and strobe decode.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = stop_pending;
    ir_load      = 1'b0;
    exec_en      = 1'b0;
    retire       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          // start+stop together runs exactly one instruction
          state_next   = FETCH;
          pending_next = stop;
        end
`ifdef PATP_CTRL_SINGLE_STEP_EN
        else if (step) begin
          state_next   = FETCH;
          pending_next = 1'b1;
        end
`endif
      end
      FETCH: begin
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_next    = pc + 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (ir_opcode == OP_LOAD || ir_opcode == OP_STORE) begin
          state_next = MEM;
        end else begin
          exec_en = 1'b1;
          retire  = 1'b1;
          if (ir_opcode == OP_JUMP || (ir_opcode == OP_BUZ && acc_zero)) begin
            pc_next = ir_operand;
          end
        end
      end
      MEM: begin
        if (mem_ready) begin
          exec_en = 1'b1;
          retire  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Instruction boundary: halt if a stop was seen earlier or is seen now.
    if (retire) begin
      state_next = (stop_pending || stop) ? IDLE : FETCH;
    end

    if (state != IDLE && stop) begin
      pending_next = 1'b1;
    end

    if (state_next == IDLE) begin
      pending_next = 1'b0;
    end
  end

  // State, pc, IR and registered memory request. The request fields are
  // derived from the next state so they hold steady across wait cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      stop_pending <= 1'b0;
      ir_opcode    <= '0;
      ir_operand   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      stop_pending <= pending_next;
      if (ir_load) begin
        ir_opcode  <= mem_rdata[DATA_W-1 -: 3];
        ir_operand <= mem_rdata[ADDR_W-1:0];
      end
      mem_req  <= (state_next == FETCH) || (state_next == MEM);
      mem_we   <= (state_next == MEM) && (ir_opcode == OP_STORE);
      mem_addr <= (state_next == MEM) ? ir_operand : pc_next;
    end
  end

  assign running = (state != IDLE);

endmodule

// File: doc/patp_control_unit.md
# patp_control_unit

Fetch/execute sequencer for the PATP core. Owns the program counter and instruction register, drives the single-port program/data memory through a req/ready handshake, and issues the one-cycle `exec_en` strobe that gates the instruction decoder. Sits between the memory and the decoder/accumulator datapath.

## Interface
- `ADDR_W`, 5: memory address width; also operand-field width.
- `DATA_W`, 8: memory word width; opcode is `mem_rdata[DATA_W-1:DATA_W-3]`, operand is `mem_rdata[ADDR_W-1:0]`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin execution from IDLE at the current `pc`.
- `stop`  in  1  request halt at the next instruction boundary.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_rdata`  in  DATA_W  memory read data; valid when `mem_ready` is high.
- `acc_zero`  in  1  accumulator-equals-zero flag.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  request is a write (STORE).
- `mem_addr`  out  ADDR_W  request address.
- `ir_opcode`  out  3  latched opcode; feeds the decoder.
- `ir_operand`  out  ADDR_W  latched operand (ADD immediate, JUMP/BUZ target, LOAD/STORE address).
- `pc`  out  ADDR_W  program counter.
- `exec_en`  out  1  one-cycle decoder enable; the datapath acts on this cycle.
- `retire`  out  1  one-cycle pulse, last cycle of each instruction.
- `running`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FETCH, EXEC, MEM.
- IDLE: all strobes low. `start`=1 → FETCH.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. When `mem_ready`=1: capture opcode/operand into IR, `pc`←`pc`+1 mod 2^ADDR_W, → EXEC.
- EXEC, opcodes 000 CLEAR, 001 INC, 010 ADD, 011 DEC: `exec_en`=1, `retire`=1, → next.
- EXEC, 100 JUMP: `exec_en`=1, `retire`=1, `pc`←`ir_operand`, → next.
- EXEC, 101 BUZ: `exec_en`=1, `retire`=1; `pc`←`ir_operand` only if `acc_zero`=1 in this cycle; → next.
- EXEC, 110 LOAD / 111 STORE: no strobe, → MEM.
- MEM: `mem_req`=1, `mem_addr`=`ir_operand`, `mem_we`=1 for STORE only. In the cycle `mem_ready`=1, `exec_en`=1 and `retire`=1; the accumulator captures `mem_rdata` (LOAD) or memory captures accumulator data (STORE). Then → next.
- "next" = IDLE if `stop_pending`, or if `stop` is high in the retiring cycle; otherwise FETCH. `stop_pending` clears on entering IDLE.
- `stop` sampled while running sets `stop_pending`. `stop` in IDLE is ignored. `start` while running is ignored.
- `start` and `stop` both high in IDLE: start wins and `stop_pending` is set. Exactly one instruction executes, then IDLE.

## Timing
- Reset (async): state IDLE, `pc`=0, IR=0, `stop_pending`=0. All outputs 0 immediately, including `mem_req`, even mid-handshake.
- Handshake: `mem_req`, `mem_we` and `mem_addr` are registered and held stable until a cycle with `mem_ready`=1. That cycle completes the transfer, and `mem_req` deasserts next cycle unless a new request follows. `mem_ready` without `mem_req` is ignored.
- Zero-wait memory: the ALU, JUMP and BUZ instructions take 2 cycles (FETCH, EXEC). LOAD/STORE take 3 (FETCH, EXEC, MEM). Each memory wait cycle adds one cycle.
- After `start` in IDLE, `mem_req` rises on the next clock edge.
- `pc` wraps from 2^ADDR_W−1 to 0 on fetch. A JUMP to the current address is legal (infinite loop; `stop` still exits).
- `exec_en` and `retire` are never high for more than one consecutive cycle per instruction.

## Configuration
- `PATP_CTRL_SINGLE_STEP_EN` defined: adds input `step` (1 bit). In IDLE, `step`=1 runs exactly one instruction: `stop_pending` is forced to 1 and the block returns to IDLE after retire. `start` has priority over `step`.
- Undefined: no `step` port and no single-step logic; behaviour as above.

## Test plan
- Reset, memory[0]=8'b001_00000 (INC), `mem_ready` tied 1, pulse `start` → FETCH then EXEC; `exec_en`=1 on cycle 2 with `ir_opcode`=001; `pc`=1.
- JUMP: memory[3]=8'b100_01010 → after retire `pc`=10, next `mem_addr`=10. BUZ 8'b101_00101 with `acc_zero`=0 → `pc`=4; with `acc_zero`=1 → `pc`=5.
- STORE 8'b111_00111, `mem_ready` low 3 cycles in MEM → `mem_req`=1, `mem_we`=1, `mem_addr`=7 stable throughout; `exec_en` only in the ready cycle; 6 cycles total.
- `pc`=31 fetch → `pc`=0. `stop` pulsed mid-LOAD → LOAD retires, then IDLE, `running`=0, `pc` held.
- Assert `rst` during MEM wait → `mem_req`=0 same cycle, `pc`=0, IDLE; `start` afterwards fetches address 0.
- With `PATP_CTRL_SINGLE_STEP_EN`: three `step` pulses over a DEC, ADD, CLEAR program → exactly three retires, IDLE between each.
